// File: rtl/fpu_result_buffer_if.sv
// Handshake bundle between the FP add stage, the result buffer and its consumer.
// The buffer uses the slave modport; the producer/consumer environment uses master.
interface fpu_result_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_overflow;
  logic        in_error;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_error;
  logic        out_is_zero;
  logic        out_is_inf;
  logic        out_is_nan;

  modport master (
    output in_valid, in_result, in_overflow, in_error, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_error,
           out_is_zero, out_is_inf, out_is_nan
  );

  modport slave (
    input  in_valid, in_result, in_overflow, in_error, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_error,
           out_is_zero, out_is_inf, out_is_nan
  );
endinterface

// File: rtl/fpu_result_buffer.sv
// Show-ahead result FIFO behind the FP adder: classifies words on write and keeps
// sticky overflow/error status plus a saturating error-event counter.
module fpu_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fpu_result_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_overflow,
  output logic                     sticky_error,
  output logic [CNT_W-1:0]         err_count,
  input  logic                     sticky_clear
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      word_q [DEPTH];
  logic             ovf_q  [DEPTH];
  logic             err_q  [DEPTH];
  logic [2:0]       cls_q  [DEPTH];  // {nan, inf, zero}
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [7:0]       in_exp;
  logic [22:0]      in_frac;
  logic [2:0]       in_cls;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign push   = bus.in_valid & ~full;
  assign pop    = bus.out_ready & ~empty;

  assign in_exp  = bus.in_result[30:23];
  assign in_frac = bus.in_result[22:0];
  assign in_cls  = {(in_exp == 8'hFF) && (in_frac != '0),
                    (in_exp == 8'hFF) && (in_frac == '0),
                    (in_exp == 8'h00) && (in_frac == '0)};

  // Storage needs no reset: every observable read is masked by empty.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      word_q[wr_ptr] <= bus.in_result;
      ovf_q[wr_ptr]  <= bus.in_overflow;
      err_q[wr_ptr]  <= bus.in_error;
      cls_q[wr_ptr]  <= in_cls;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      sticky_overflow <= 1'b0;
      sticky_error    <= 1'b0;
      err_count       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase

      // A flagged push in the same cycle as a clear wins over the clear.
      if (push && bus.in_overflow) sticky_overflow <= 1'b1;
      else if (sticky_clear)       sticky_overflow <= 1'b0;

      if (push && bus.in_error)    sticky_error <= 1'b1;
      else if (sticky_clear)       sticky_error <= 1'b0;

      if (push && bus.in_error) begin
        if (sticky_clear)            err_count <= CNT_W'(1);
        else if (err_count != '1)    err_count <= err_count + CNT_W'(1);
      end else if (sticky_clear) begin
        err_count <= '0;
      end
    end
  end

  always_comb begin
    bus.in_ready     = ~full;
    bus.out_valid    = ~empty;
    bus.out_result   = '0;
    bus.out_overflow = 1'b0;
    bus.out_error    = 1'b0;
    bus.out_is_zero  = 1'b0;
    bus.out_is_inf   = 1'b0;
    bus.out_is_nan   = 1'b0;
    if (!empty) begin
      bus.out_result   = word_q[rd_ptr];
      bus.out_overflow = ovf_q[rd_ptr];
      bus.out_error    = err_q[rd_ptr];
      bus.out_is_zero  = cls_q[rd_ptr][0];
      bus.out_is_inf   = cls_q[rd_ptr][1];
      bus.out_is_nan   = cls_q[rd_ptr][2];
    end
  end
endmodule
